// File: rtl/top_ser_ctrl.sv
// Multi-channel serial controller on the top-level bus slave port.
// Each channel has one TX shift stage and one RX receive register with flags.
module top_ser_ctrl #(
  parameter int chan_p  = 2,
  parameter int width_p = 8
) (
  input  logic              main_clk_i,
  input  logic              main_rst_i,
  input  logic [1:0]        bus_trans_i,
  input  logic [31:0]       bus_addr_i,
  input  logic              bus_write_i,
  input  logic [31:0]       bus_wdata_i,
  output logic              bus_ready_o,
  output logic              bus_resp_o,
  output logic [31:0]       bus_rdata_o,
  output logic [chan_p-1:0] ser_tx_o,
  input  logic [chan_p-1:0] ser_rx_i
);
  localparam logic [1:0] st_idle  = 2'd0;
  localparam logic [1:0] st_start = 2'd1;
  localparam logic [1:0] st_data  = 2'd2;
  localparam logic [1:0] st_stop  = 2'd3;
  localparam int bw = $clog2(width_p);

  logic [15:0]        div_q;
  logic               en_q;
  logic               ready_q, resp_q;
  logic [31:0]        rdata_q;
  logic [chan_p-1:0]  tx_busy, rx_valid, rx_ovf, rx_ferr;
  logic [chan_p-1:0]  tx_load, rx_rd, ovf_clr, ferr_clr;
  logic [width_p-1:0] rx_data [chan_p];
  logic               req, resp_n, ctrl_wr;
  logic [31:0]        rdata_n, status;
  logic [5:0]         word;
  logic               unused_bits;

  assign unused_bits = ^{bus_addr_i[31:8], bus_addr_i[1:0], bus_wdata_i};
  assign word        = bus_addr_i[7:2];
  // A request sitting on the bus during its own ready cycle is not a new access.
  assign req         = (bus_trans_i != 2'b00) && !ready_q;

  always_comb begin
    status = '0;
    status[chan_p-1:0]  = tx_busy;
    status[8 +: chan_p]  = rx_valid;
    status[16 +: chan_p] = rx_ovf;
    status[24 +: chan_p] = rx_ferr;
  end

  always_comb begin
    resp_n   = 1'b0;
    rdata_n  = '0;
    ctrl_wr  = 1'b0;
    tx_load  = '0;
    rx_rd    = '0;
    ovf_clr  = '0;
    ferr_clr = '0;
    if (req) begin
      resp_n = 1'b1;
      if (word == 6'd0) begin
        resp_n = 1'b0;
        if (bus_write_i) ctrl_wr = 1'b1;
        else             rdata_n = {en_q, 15'd0, div_q};
      end else if (word == 6'd1) begin
        resp_n = 1'b0;
        if (bus_write_i) begin
          ovf_clr  = bus_wdata_i[16 +: chan_p];
          ferr_clr = bus_wdata_i[24 +: chan_p];
        end else begin
          rdata_n = status;
        end
      end
      for (int c = 0; c < chan_p; c++) begin
        if (word == 6'(4 + c)) begin
          resp_n = 1'b0;
          if (bus_write_i) begin
            if (en_q && !tx_busy[c]) tx_load[c] = 1'b1;
            else                     resp_n = 1'b1;
          end
        end
        if (word == 6'(12 + c)) begin
          resp_n = bus_write_i;
          if (!bus_write_i) begin
            rdata_n  = 32'(rx_data[c]);
            rx_rd[c] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      ready_q <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      div_q   <= 16'h000F;
      en_q    <= 1'b0;
    end else begin
      ready_q <= req;
      resp_q  <= req && resp_n;
      rdata_q <= req ? rdata_n : 32'd0;
      if (ctrl_wr) begin
        div_q <= bus_wdata_i[15:0];
        en_q  <= bus_wdata_i[31];
      end
    end
  end

  assign bus_ready_o = ready_q;
  assign bus_resp_o  = resp_q;
  assign bus_rdata_o = rdata_q;

  for (genvar g = 0; g < chan_p; g++) begin : g_chan
    logic [1:0]         tx_st, rx_st;
    logic [15:0]        tx_cnt, rx_cnt;
    logic [bw-1:0]      tx_bit, rx_bit;
    logic [width_p-1:0] tx_sh, rx_sh, data_q;
    logic               tx_q, s1, s2, s3;
    logic               valid_q, ovf_q, ferr_q, rx_ok, rx_err, stop_smp;

    // Line is registered from the current state, so it trails the FSM by one cycle.
    always_ff @(posedge main_clk_i) begin
      if (main_rst_i) begin
        tx_st  <= st_idle;
        tx_cnt <= '0;
        tx_bit <= '0;
        tx_sh  <= '0;
        tx_q   <= 1'b1;
      end else if (!en_q) begin
        tx_st  <= st_idle;
        tx_cnt <= '0;
        tx_bit <= '0;
        tx_q   <= 1'b1;
      end else begin
        tx_q <= (tx_st == st_start) ? 1'b0 : (tx_st == st_data) ? tx_sh[0] : 1'b1;
        if (tx_st == st_idle) begin
          if (tx_load[g]) begin
            tx_st  <= st_start;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= bus_wdata_i[width_p-1:0];
          end
        end else if (tx_cnt >= div_q) begin
          tx_cnt <= '0;
          case (tx_st)
            st_start: tx_st <= st_data;
            st_data: begin
              tx_sh  <= tx_sh >> 1;
              tx_bit <= tx_bit + 1'b1;
              if (tx_bit == bw'(width_p - 1)) tx_st <= st_stop;
            end
            default: tx_st <= st_idle;
          endcase
        end else begin
          tx_cnt <= tx_cnt + 16'd1;
        end
      end
    end

    assign tx_busy[g]  = (tx_st != st_idle);
    assign ser_tx_o[g] = tx_q;

    always_ff @(posedge main_clk_i) begin
      if (main_rst_i) begin
        s1     <= 1'b1;
        s2     <= 1'b1;
        s3     <= 1'b1;
        rx_st  <= st_idle;
        rx_cnt <= '0;
        rx_bit <= '0;
        rx_sh  <= '0;
      end else begin
        s1 <= ser_rx_i[g];
        s2 <= s1;
        s3 <= s2;
        if (!en_q) begin
          rx_st  <= st_idle;
          rx_cnt <= '0;
        end else begin
          case (rx_st)
            st_idle: begin
              rx_cnt <= '0;
              if (s3 && !s2) rx_st <= st_start;
            end
            st_start: begin
              if (rx_cnt >= {1'b0, div_q[15:1]}) begin
                rx_cnt <= '0;
                rx_bit <= '0;
                rx_st  <= s2 ? st_idle : st_data;
              end else begin
                rx_cnt <= rx_cnt + 16'd1;
              end
            end
            st_data: begin
              if (rx_cnt >= div_q) begin
                rx_cnt <= '0;
                rx_sh  <= {s2, rx_sh[width_p-1:1]};
                rx_bit <= rx_bit + 1'b1;
                if (rx_bit == bw'(width_p - 1)) rx_st <= st_stop;
              end else begin
                rx_cnt <= rx_cnt + 16'd1;
              end
            end
            default: begin
              if (rx_cnt >= div_q) begin
                rx_cnt <= '0;
                rx_st  <= st_idle;
              end else begin
                rx_cnt <= rx_cnt + 16'd1;
              end
            end
          endcase
        end
      end
    end

    assign stop_smp = en_q && (rx_st == st_stop) && (rx_cnt >= div_q);
    assign rx_ok    = stop_smp && s2;
    assign rx_err   = stop_smp && !s2;

    // Setting a flag takes priority over a read-clear or W1C in the same cycle.
    always_ff @(posedge main_clk_i) begin
      if (main_rst_i) begin
        data_q  <= '0;
        valid_q <= 1'b0;
        ovf_q   <= 1'b0;
        ferr_q  <= 1'b0;
      end else begin
        if (rx_ok) begin
          data_q  <= rx_sh;
          valid_q <= 1'b1;
        end else if (rx_rd[g]) begin
          valid_q <= 1'b0;
        end
        if (rx_ok && valid_q && !rx_rd[g]) ovf_q <= 1'b1;
        else if (ovf_clr[g])               ovf_q <= 1'b0;
        if (rx_err)           ferr_q <= 1'b1;
        else if (ferr_clr[g]) ferr_q <= 1'b0;
      end
    end

    assign rx_data[g]  = data_q;
    assign rx_valid[g] = valid_q;
    assign rx_ovf[g]   = ovf_q;
    assign rx_ferr[g]  = ferr_q;
  end
endmodule
